tile_fetch: RTL and testbench
=============================

TILE_FETCH -- requirements
Module: tile_fetch

Interface
REQ-001 SHALL have parameter GRID_W_LOG2, default 5, meaning log2 of grid columns (32 cells of 8 px).
REQ-002 SHALL have parameter GRID_H_LOG2, default 5, meaning log2 of grid rows (32 cells of 8 px).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hpos  input  9  beam X pixel position.
REQ-006 SHALL have port vpos  input  9  beam Y pixel position.
REQ-007 SHALL have port display_on  input  1  beam in visible area.
REQ-008 SHALL have port tile_type  output  2  cell tile type for the downstream tile renderer.
REQ-009 SHALL have port rotation  output  2  cell rotation, 0..3 quarter turns.
REQ-010 SHALL have port yin  output  3  row within the 8x8 tile.
REQ-011 SHALL have port xin  output  3  column within the 8x8 tile.
REQ-012 SHALL have port tile_valid  output  1  outputs describe an in-grid visible pixel.
REQ-013 SHALL have port cmd_valid  input  1  command request.
REQ-014 SHALL have port cmd_ready  output  1  command accepted when both cmd_valid and cmd_ready are high.
REQ-015 SHALL have port cmd_op  input  2  command: 00 WRITE, 01 ROTATE, 10 CLEAR_ALL, 11 reserved.
REQ-016 SHALL have port cmd_x  input  GRID_W_LOG2  target cell column.
REQ-017 SHALL have port cmd_y  input  GRID_H_LOG2  target cell row.
REQ-018 SHALL have port cmd_data  input  4  WRITE payload, {tile_type, rotation}.
REQ-019 SHALL have port cmd_done  output  1  one-cycle pulse when a command completes.

Function
REQ-020 SHALL hold a 2^(GRID_W_LOG2+GRID_H_LOG2) x 4-bit map RAM; entry = {type[3:2], rot[1:0]}; address = {cell_y, cell_x}.
REQ-021 SHALL have the scan path sample hpos/vpos at cycle N, read the cell {vpos[7:3], hpos[7:3]} (low GRID bits), and present registered outputs at cycle N+2, a fixed latency of 2 clocks.
REQ-022 SHALL drive xin = hpos[2:0] and yin = vpos[2:0], delayed 2 clocks to align with the RAM data.
REQ-023 SHALL treat a pixel as out-of-grid when display_on=0 or the cell index exceeds the grid; it then sets tile_valid=0 and tile_type=rotation=xin=yin=0.
REQ-024 SHALL give the scan read port its own RAM port; it is never stalled by commands, and a same-cycle write to the same cell returns the old data.
REQ-025 SHALL have the command FSM use states IDLE, RD, WR, CLR; cmd_ready=1 only in IDLE.
REQ-026 SHALL process WRITE as IDLE -> WR (writes cmd_data) -> IDLE, with cmd_done asserted in the WR cycle.
REQ-027 SHALL process ROTATE as IDLE -> RD (reads cell) -> WR (writes {type, rot+1 mod 4}; 3 wraps to 0) -> IDLE, with cmd_done asserted in the WR cycle.
REQ-028 SHALL process CLEAR_ALL as IDLE -> CLR; one cell per cycle is written with 0 from address 0 upward; after the last address it returns to IDLE, asserting cmd_done on the final write.
REQ-029 SHALL latch cmd_x/cmd_y/cmd_data/cmd_op on acceptance; later changes on those inputs are ignored.
REQ-030 SHALL process the reserved op 11 as IDLE -> WR with no write, while still pulsing cmd_done.
REQ-031 SHALL ignore cmd_valid while not in IDLE; the command is not accepted and the requester holds it.

Reset
REQ-032 SHALL on reset force FSM=IDLE, cmd_done=0, tile_valid=0, and all scan output and pipeline registers to 0 on the next edge.
REQ-033 SHALL leave map RAM contents unchanged by reset; reset during RD/WR/CLR aborts the operation, so a partial clear remains.

Configuration
REQ-034 SHALL gate CLEAR_ALL support on macro TILE_FETCH_CLEAR_EN; when defined, op 10 behaves per REQ-028.
REQ-035 SHALL, without TILE_FETCH_CLEAR_EN, omit the CLR state and clear counter, and process op 10 like reserved op 11 (no write, cmd_done pulse).

Verification
REQ-036 SHALL cover: WRITE x=3,y=2,data=4'b1001 -> cmd_done 1 clk after accept; scanning hpos=27,vpos=21 gives tile_type=2, rotation=1, xin=3, yin=5, tile_valid=1 exactly 2 clocks later.
REQ-037 SHALL cover: ROTATE the same cell 4 times -> rotation reads 2,3,0,1; tile_type stays 2; each command holds cmd_ready low for 2 cycles.
REQ-038 SHALL cover: with TILE_FETCH_CLEAR_EN, CLEAR_ALL -> cmd_ready low 1024 cycles, single cmd_done, every cell scans tile_type=0; without the macro -> cmd_done after 1 cycle and map unchanged.
REQ-039 SHALL cover: hpos=300 or display_on=0 -> tile_valid=0 and all fields 0 two clocks later.
REQ-040 SHALL cover: reset asserted at CLR address 100 -> next cycle IDLE, cmd_ready=1, outputs 0; cells 0..99 are 0 and cell 200 is unchanged.
REQ-041 SHALL cover: a WRITE committed to the cell being scanned in the same cycle -> the scan output shows the old value, and the new value on the following scan.

Source files
------------

// File: rtl/tile_fetch.sv
// Tile map fetch: a 2-clock scan pipeline reads a cell map and a command FSM edits it.
// Optional CLEAR_ALL support is enabled by defining TILE_FETCH_CLEAR_EN.
module tile_fetch #(
  parameter int GRID_W_LOG2 = 5,
  parameter int GRID_H_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8:0]             hpos,
  input  logic [8:0]             vpos,
  input  logic                   display_on,
  output logic [1:0]             tile_type,
  output logic [1:0]             rotation,
  output logic [2:0]             yin,
  output logic [2:0]             xin,
  output logic                   tile_valid,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [GRID_W_LOG2-1:0] cmd_x,
  input  logic [GRID_H_LOG2-1:0] cmd_y,
  input  logic [3:0]             cmd_data,
  output logic                   cmd_done
);

  localparam int AW    = GRID_W_LOG2 + GRID_H_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [6:0] GRID_W = 7'(1 << GRID_W_LOG2);
  localparam logic [6:0] GRID_H = 7'(1 << GRID_H_LOG2);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_ROTATE = 2'b01;
`ifdef TILE_FETCH_CLEAR_EN
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [AW-1:0] CLR_LAST = '1;
  localparam logic [AW-1:0] CLR_PENULT = CLR_LAST - AW'(1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
`ifdef TILE_FETCH_CLEAR_EN
    WR   = 2'd2,
    CLR  = 2'd3
`else
    WR   = 2'd2
`endif
  } state_t;

  function automatic logic [3:0] rotate_cell(input logic [3:0] c);
    return {c[3:2], c[1:0] + 2'd1};
  endfunction

  function automatic logic [3:0] gate_cell(input logic v, input logic [3:0] c);
    return v ? c : 4'd0;
  endfunction

  logic [3:0] map_mem [DEPTH];

  // ---------------- scan path ----------------
  logic [5:0]    hcell, vcell;
  logic          in_grid;
  logic [AW-1:0] scan_addr;

  assign hcell     = hpos[8:3];
  assign vcell     = vpos[8:3];
  assign in_grid   = display_on && ({1'b0, hcell} < GRID_W) && ({1'b0, vcell} < GRID_H);
  assign scan_addr = {vcell[GRID_H_LOG2-1:0], hcell[GRID_W_LOG2-1:0]};

  logic [3:0] cell_p1;
  logic [2:0] xin_p1, yin_p1;
  logic       vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      cell_p1    <= 4'd0;
      xin_p1     <= 3'd0;
      yin_p1     <= 3'd0;
      tile_valid <= 1'b0;
      tile_type  <= 2'd0;
      rotation   <= 2'd0;
      xin        <= 3'd0;
      yin        <= 3'd0;
    end else begin
      // stage p1: RAM read, pixel offsets carried alongside
      vld_p1     <= in_grid;
      cell_p1    <= map_mem[scan_addr];
      xin_p1     <= hpos[2:0];
      yin_p1     <= vpos[2:0];
      // stage p2: registered outputs, zeroed for out-of-grid pixels
      tile_valid <= vld_p1;
      {tile_type, rotation} <= gate_cell(vld_p1, cell_p1);
      xin        <= vld_p1 ? xin_p1 : 3'd0;
      yin        <= vld_p1 ? yin_p1 : 3'd0;
    end
  end

  // ---------------- command path ----------------
  state_t        state;
  logic [1:0]    op_r;
  logic [GRID_W_LOG2-1:0] x_r;
  logic [GRID_H_LOG2-1:0] y_r;
  logic [3:0]    data_r;
  logic [3:0]    rd_cmd;
  logic [AW-1:0] cmd_addr;
`ifdef TILE_FETCH_CLEAR_EN
  logic [AW-1:0] clr_cnt;
`endif

  assign cmd_addr = {y_r, x_r};

  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      op_r   <= cmd_op;
      x_r    <= cmd_x;
      y_r    <= cmd_y;
      data_r <= cmd_data;
    end
    if (state == RD)
      rd_cmd <= map_mem[cmd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      cmd_done  <= 1'b0;
`ifdef TILE_FETCH_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_done <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_ROTATE: state <= RD;
`ifdef TILE_FETCH_CLEAR_EN
              OP_CLEAR: begin
                state   <= CLR;
                clr_cnt <= '0;
              end
`endif
              default: begin
                state    <= WR;
                cmd_done <= 1'b1;
              end
            endcase
          end
        end
        RD: begin
          state    <= WR;
          cmd_done <= 1'b1;
        end
        WR: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          cmd_done  <= 1'b0;
        end
`ifdef TILE_FETCH_CLEAR_EN
        CLR: begin
          clr_cnt  <= clr_cnt + AW'(1);
          cmd_done <= (clr_cnt == CLR_PENULT);
          if (clr_cnt == CLR_LAST) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            cmd_done  <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          cmd_done  <= 1'b0;
        end
      endcase
    end
  end

  // Write port: reset suppresses the write in flight so an aborted clear stops cleanly
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [3:0]    mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cmd_addr;
    mem_wdata = data_r;
    case (state)
      WR: begin
        if (op_r == OP_WRITE) begin
          mem_we = 1'b1;
        end else if (op_r == OP_ROTATE) begin
          mem_we    = 1'b1;
          mem_wdata = rotate_cell(rd_cmd);
        end
      end
`ifdef TILE_FETCH_CLEAR_EN
      CLR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = 4'd0;
      end
`endif
      default: mem_we = 1'b0;
    endcase
    if (reset)
      mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      map_mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_tile_fetch.sv
// Directed bench for tile_fetch: commands, scan latency, grid bounds, reset and clear behaviour.
// Define TILE_FETCH_CLEAR_EN for both RTL and bench to exercise CLEAR_ALL.
module tb_tile_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       display_on;
  logic [1:0] tile_type, rotation;
  logic [2:0] yin, xin;
  logic       tile_valid;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_x, cmd_y;
  logic [3:0] cmd_data;
  logic       cmd_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tile_fetch dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .tile_type(tile_type), .rotation(rotation), .yin(yin), .xin(xin),
    .tile_valid(tile_valid), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .cmd_done(cmd_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply a pixel, wait the 2-clock latency, check all scan outputs.
  task automatic scan_chk(input string tag, input int h, input int v, input logic don,
                          input logic [1:0] et, input logic [1:0] er);
    logic ev;
    hpos = 9'(h); vpos = 9'(v); display_on = don;
    ev = don && (h < 256) && (v < 256);
    tick(); tick();
    chk({tag, ".valid"}, tile_valid, ev);
    chk({tag, ".type"},  tile_type, ev ? et : 2'd0);
    chk({tag, ".rot"},   rotation,  ev ? er : 2'd0);
    chk({tag, ".xin"},   xin, ev ? 3'(h % 8) : 3'd0);
    chk({tag, ".yin"},   yin, ev ? 3'(v % 8) : 3'd0);
  endtask

  // Issue one command; busy = cycles cmd_ready stays low, cmd_done expected on the last.
  task automatic send_cmd(input string tag, input logic [1:0] op, input int x, input int y,
                          input logic [3:0] d, input int busy);
    chk({tag, ".ready_idle"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = 5'(x); cmd_y = 5'(y); cmd_data = d;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_x = ~cmd_x; cmd_y = ~cmd_y; cmd_data = ~d;
    for (int i = 1; i <= busy; i++) begin
      chk({tag, ".ready_busy"}, cmd_ready, 1'b0);
      chk({tag, ".done"}, cmd_done, (i == busy));
      tick();
    end
    chk({tag, ".ready_back"}, cmd_ready, 1'b1);
    chk({tag, ".done_clr"}, cmd_done, 1'b0);
  endtask

  initial begin
    int cycles;
    int dones;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_x = '0; cmd_y = '0; cmd_data = '0;
    hpos = '0; vpos = '0; display_on = 1'b0;
    tick(); tick(); tick();
    chk("rst.valid", tile_valid, 1'b0);
    chk("rst.type",  tile_type, 2'd0);
    chk("rst.done",  cmd_done, 1'b0);
    chk("rst.ready", cmd_ready, 1'b1);
    reset = 1'b0;
    tick();

    // WRITE then scan with exact 2-clock latency
    send_cmd("wr32", 2'b00, 3, 2, 4'b1001, 1);
    hpos = 9'd27; vpos = 9'd21; display_on = 1'b1;
    tick();
    chk("lat.one_clk_valid", tile_valid, 1'b0);
    tick();
    chk("lat.valid", tile_valid, 1'b1);
    chk("lat.type",  tile_type, 2'd2);
    chk("lat.rot",   rotation, 2'd1);
    chk("lat.xin",   xin, 3'd3);
    chk("lat.yin",   yin, 3'd5);

    // ROTATE four times: 2,3,0,1
    send_cmd("rot1", 2'b01, 3, 2, 4'b0000, 2);
    scan_chk("rot1s", 27, 21, 1'b1, 2'd2, 2'd2);
    send_cmd("rot2", 2'b01, 3, 2, 4'b0000, 2);
    scan_chk("rot2s", 27, 21, 1'b1, 2'd2, 2'd3);
    send_cmd("rot3", 2'b01, 3, 2, 4'b0000, 2);
    scan_chk("rot3s", 27, 21, 1'b1, 2'd2, 2'd0);
    send_cmd("rot4", 2'b01, 3, 2, 4'b0000, 2);
    scan_chk("rot4s", 27, 21, 1'b1, 2'd2, 2'd1);

    // Grid bounds and blanking
    scan_chk("h300", 300, 21, 1'b1, 2'd0, 2'd0);
    scan_chk("blank", 27, 21, 1'b0, 2'd0, 2'd0);
    send_cmd("wr3131", 2'b00, 31, 31, 4'b1110, 1);
    scan_chk("corner", 255, 255, 1'b1, 2'd3, 2'd2);
    scan_chk("v256", 255, 256, 1'b1, 2'd0, 2'd0);

    // Reserved op: done pulse, map unchanged
    send_cmd("op11", 2'b11, 3, 2, 4'b0000, 1);
    scan_chk("op11s", 27, 21, 1'b1, 2'd2, 2'd1);

`ifdef TILE_FETCH_CLEAR_EN
    send_cmd("wr200", 2'b00, 8, 6, 4'b1011, 1);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b00;
    cycles = 0; dones = 0;
    while (cmd_ready !== 1'b1 && cycles < 2000) begin
      if (cmd_done === 1'b1) dones++;
      cycles++;
      tick();
    end
    chk("clr.busy_cycles", cycles, 1024);
    chk("clr.done_pulses", dones, 1);
    display_on = 1'b1;
    for (int i = 0; i <= 1024; i++) begin
      if (i < 1024) begin
        hpos = 9'((i % 32) * 8 + (i % 8));
        vpos = 9'((i / 32) * 8);
      end
      tick();
      if (i >= 1) chk("clr.cell", {tile_valid, tile_type}, 3'b100);
    end

    // Partial clear aborted by reset at address 100
    send_cmd("wr50",  2'b00, 18, 1, 4'b0110, 1);
    send_cmd("wr99",  2'b00, 3, 3, 4'b1101, 1);
    send_cmd("wr100", 2'b00, 4, 3, 4'b0101, 1);
    send_cmd("wr200b", 2'b00, 8, 6, 4'b1011, 1);
    hpos = 9'd27; vpos = 9'd21; display_on = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b00;
    repeat (100) tick();
    chk("pclr.busy", cmd_ready, 1'b0);
    chk("pclr.valid_pre", tile_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk("pclr.ready", cmd_ready, 1'b1);
    chk("pclr.done",  cmd_done, 1'b0);
    chk("pclr.valid", tile_valid, 1'b0);
    chk("pclr.type",  tile_type, 2'd0);
    reset = 1'b0;
    scan_chk("pclr.c50",  18 * 8, 1 * 8, 1'b1, 2'd0, 2'd0);
    scan_chk("pclr.c99",  3 * 8, 3 * 8, 1'b1, 2'd0, 2'd0);
    scan_chk("pclr.c100", 4 * 8, 3 * 8, 1'b1, 2'd1, 2'd1);
    scan_chk("pclr.c200", 8 * 8, 6 * 8, 1'b1, 2'd2, 2'd3);
`else
    send_cmd("op10", 2'b10, 3, 2, 4'b0000, 1);
    scan_chk("op10s", 27, 21, 1'b1, 2'd2, 2'd1);
`endif

    // Same-cycle write to the scanned cell: old value first, new value next
    send_cmd("wrold", 2'b00, 3, 2, 4'b1001, 1);
    scan_chk("pre_same", 27, 21, 1'b1, 2'd2, 2'd1);
    send_cmd("wrsame", 2'b00, 3, 2, 4'b0111, 1);
    tick();
    chk("same.old_type", tile_type, 2'd2);
    chk("same.old_rot",  rotation, 2'd1);
    tick();
    chk("same.new_type", tile_type, 2'd1);
    chk("same.new_rot",  rotation, 2'd3);

    // Reset while scanning a valid cell clears outputs on the next edge
    reset = 1'b1;
    tick();
    chk("rst2.valid", tile_valid, 1'b0);
    chk("rst2.type",  tile_type, 2'd0);
    chk("rst2.rot",   rotation, 2'd0);
    chk("rst2.xin",   xin, 3'd0);
    chk("rst2.yin",   yin, 3'd0);
    chk("rst2.ready", cmd_ready, 1'b1);
    reset = 1'b0;
    scan_chk("post_rst", 27, 21, 1'b1, 2'd1, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
